// File: rtl/icache_fetch_if.sv
// Fetch-port and backing-memory signal bundle for icache_fetch.
// slave = the cache's view; master = the core/backing-memory side.
interface icache_fetch_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_oe;
  logic [31:0]       imem_rdata;
  logic              imem_ready;
  logic              inv;
  logic [ADDR_W-1:0] bk_addr;
  logic              bk_req;
  logic [31:0]       bk_rdata;
  logic              bk_ack;

  modport master (
    output imem_addr, imem_oe, inv, bk_rdata, bk_ack,
    input  imem_rdata, imem_ready, bk_addr, bk_req
  );

  modport slave (
    input  imem_addr, imem_oe, inv, bk_rdata, bk_ack,
    output imem_rdata, imem_ready, bk_addr, bk_req
  );
endinterface

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache with single-word sequential line refill.
// Define ICACHE_PERF_EN to add the hit_cnt/miss_cnt lookup counters.
module icache_fetch #(
  parameter int ADDR_W     = 16,
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic          clk,
  input  logic          rst,
  icache_fetch_if.slave bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
`endif
);
  localparam int DATA_W = 32;
  localparam int WB     = $clog2(LINE_WORDS);
  localparam int IB     = $clog2(LINES);
  localparam int TB     = ADDR_W - 2 - WB - IB;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] FILL   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [WB-1:0] LAST_WORD = WB'(LINE_WORDS - 1);

  logic [1:0]        state;
  logic [LINES-1:0]  valid;
  logic [WB-1:0]     k;
  logic              inv_seen;
  logic [DATA_W-1:0] rdata_q;

  logic [TB-1:0]     req_tag_p1;
  logic [IB-1:0]     req_idx_p1;
  logic [WB-1:0]     req_word_p1;
  logic [DATA_W-1:0] dout_p1;

  logic [DATA_W-1:0] data_mem [LINES*LINE_WORDS];
  logic [TB-1:0]     tag_mem  [LINES];

  logic          hit, miss, ready, accept, fill_ack, fill_last;
  logic          unused_addr_bits;
  logic [TB-1:0] a_tag;
  logic [IB-1:0] a_idx;
  logic [WB-1:0] a_word;

  assign {a_tag, a_idx, a_word} = bus.imem_addr[ADDR_W-1:2];
  assign unused_addr_bits       = ^bus.imem_addr[1:0];

  assign hit       = (state == LOOKUP) && valid[req_idx_p1] && (tag_mem[req_idx_p1] == req_tag_p1);
  assign miss      = (state == LOOKUP) && !hit;
  assign ready     = (state == IDLE) || (state == RESP) || hit;
  assign accept    = ready && bus.imem_oe;
  assign fill_ack  = (state == FILL) && bus.bk_ack;
  assign fill_last = fill_ack && (k == LAST_WORD);

  assign bus.imem_ready = ready;
  assign bus.imem_rdata = hit ? dout_p1 : rdata_q;
  assign bus.bk_req     = (state == FILL);
  assign bus.bk_addr    = (state == FILL) ? {req_tag_p1, req_idx_p1, k, 2'b00} : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      valid    <= '0;
      k        <= '0;
      inv_seen <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE, RESP: state <= accept ? LOOKUP : IDLE;
        LOOKUP: begin
          if (hit) begin
            rdata_q <= dout_p1;
            state   <= accept ? LOOKUP : IDLE;
          end else begin
            k        <= '0;
            inv_seen <= 1'b0;
            state    <= FILL;
          end
        end
        default: begin
          if (bus.inv) inv_seen <= 1'b1;
          if (fill_ack) begin
            if (k == req_word_p1) rdata_q <= bus.bk_rdata;
            k <= k + 1'b1;
            if (k == LAST_WORD) state <= RESP;
          end
        end
      endcase

      // A line only becomes valid if no invalidate arrived while it was refilling.
      if (bus.inv)                      valid             <= '0;
      else if (miss)                    valid[req_idx_p1] <= 1'b0;
      else if (fill_last && !inv_seen)  valid[req_idx_p1] <= 1'b1;
    end
  end

  // Stage p0 -> p1: register the accepted address and start the synchronous data read.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_tag_p1  <= a_tag;
      req_idx_p1  <= a_idx;
      req_word_p1 <= a_word;
      dout_p1     <= data_mem[{a_idx, a_word}];
    end
    if (fill_ack) data_mem[{req_idx_p1, k}] <= bus.bk_rdata;
    if (fill_last) tag_mem[req_idx_p1] <= req_tag_p1;
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit)  hit_cnt  <= hit_cnt + 32'd1;
      if (miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: miss/hit timing, conflicts, slow backing, invalidate, reset mid-fill.
module tb_icache_fetch;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   wait_cycles = 0;
  int   cnt = 0;
  bit   ack_force = 1'b0;

  icache_fetch_if #(.ADDR_W(16)) bus ();

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
  icache_fetch #(.ADDR_W(16), .LINES(64), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));
`else
  icache_fetch #(.ADDR_W(16), .LINES(64), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [15:0] a);
    return 32'h1000 + 32'(a[15:2]);
  endfunction

  // Backing memory: acks after wait_cycles idle cycles per word.
  always @(negedge clk) begin
    if (ack_force) begin
      bus.bk_ack   = 1'b1;
      bus.bk_rdata = memval(bus.bk_addr);
    end else if (!bus.bk_req) begin
      bus.bk_ack = 1'b0;
      cnt        = 0;
    end else if (cnt >= wait_cycles) begin
      bus.bk_ack   = 1'b1;
      bus.bk_rdata = memval(bus.bk_addr);
      cnt          = 0;
    end else begin
      bus.bk_ack = 1'b0;
      cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic inv_pulse;
    bus.inv = 1'b1;
    tick;
    bus.inv = 1'b0;
  endtask

  // Issue one fetch from a ready cycle; lat = cycles from acceptance until ready=1.
  task automatic fetch(input logic [15:0] a, input bit toggle, input int inv_at,
                       output int lat, output logic [31:0] rd, output logic [15:0] first_bk);
    bit seen = 1'b0;
    lat      = -1;
    rd       = 32'hDEAD_BEEF;
    first_bk = 16'hFFFF;
    bus.imem_addr = a;
    bus.imem_oe   = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      tick;
      bus.inv = (n == inv_at);
      if (bus.bk_req && !seen) begin
        first_bk = bus.bk_addr;
        seen     = 1'b1;
      end
      if (bus.imem_ready) begin
        lat         = n;
        rd          = bus.imem_rdata;
        bus.imem_oe = 1'b0;
        break;
      end
      bus.imem_oe   = toggle ? ~bus.imem_oe : 1'b0;
      bus.imem_addr = toggle ? 16'h0400 : a;
    end
    tick;
    bus.inv = 1'b0;
  endtask

  int          lat;
  logic [31:0] rd;
  logic [15:0] fb;

  initial begin
    bus.imem_addr = '0;
    bus.imem_oe   = 1'b0;
    bus.inv       = 1'b0;
    tick;
    tick;
    check("rst_ready", 32'(bus.imem_ready), 32'd1);
    check("rst_rdata", bus.imem_rdata, 32'h0);
    check("rst_bkreq", 32'(bus.bk_req), 32'd0);
    check("rst_bkaddr", 32'(bus.bk_addr), 32'h0);
    @(negedge clk) rst = 1'b1;
    tick;

    // Cold miss on 0x0000 with ack tied high.
    bus.imem_addr = 16'h0000;
    bus.imem_oe   = 1'b1;
    tick;
    check("cold_rdy_t1", 32'(bus.imem_ready), 32'd0);
    bus.imem_oe = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("cold_bkreq", 32'(bus.bk_req), 32'd1);
      check("cold_bkaddr", 32'(bus.bk_addr), 32'(i * 4));
    end
    tick;
    check("cold_rdy_t6", 32'(bus.imem_ready), 32'd1);
    check("cold_rdata", bus.imem_rdata, 32'h1000);

    // Back-to-back hits, first one accepted in the RESP cycle.
    bus.imem_addr = 16'h0004;
    bus.imem_oe   = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick;
      check("b2b_ready", 32'(bus.imem_ready), 32'd1);
      check("b2b_rdata", bus.imem_rdata, 32'h1000 + 32'(i));
      check("b2b_bkreq", 32'(bus.bk_req), 32'd0);
      bus.imem_addr = 16'(4 * (i + 1));
    end
    bus.imem_oe = 1'b0;
    tick;
    check("idle_hold", bus.imem_rdata, 32'h1003);

    // Conflict on index 0.
    fetch(16'h0400, 1'b0, -1, lat, rd, fb);
    check("conf_lat", 32'(lat), 32'd6);
    check("conf_rdata", rd, 32'h1100);
    check("conf_bk", 32'(fb), 32'h0400);
    fetch(16'h0000, 1'b0, -1, lat, rd, fb);
    check("conf2_lat", 32'(lat), 32'd6);
    check("conf2_rdata", rd, 32'h1000);
    check("conf2_bk", 32'(fb), 32'h0000);
    fetch(16'h0004, 1'b0, -1, lat, rd, fb);
    check("hit_lat", 32'(lat), 32'd1);
    check("hit_rdata", rd, 32'h1001);

    // Invalidate after a filled line.
    inv_pulse;
    fetch(16'h0004, 1'b0, -1, lat, rd, fb);
    check("inv_lat", 32'(lat), 32'd6);
    check("inv_rdata", rd, 32'h1001);

    // Slow backing with imem_oe toggling while stalled.
    inv_pulse;
    wait_cycles = 3;
    fetch(16'h0008, 1'b1, -1, lat, rd, fb);
    check("slow_lat", 32'(lat), 32'd18);
    check("slow_rdata", rd, 32'h1002);
    wait_cycles = 0;
    fetch(16'h000C, 1'b0, -1, lat, rd, fb);
    check("slow_hit_lat", 32'(lat), 32'd1);
    check("slow_hit_rdata", rd, 32'h1003);

    // inv mid-fill: word delivered, line left invalid.
    fetch(16'h0010, 1'b0, 3, lat, rd, fb);
    check("invfill_lat", 32'(lat), 32'd6);
    check("invfill_rdata", rd, 32'h1004);
    fetch(16'h0010, 1'b0, -1, lat, rd, fb);
    check("invfill_re_lat", 32'(lat), 32'd6);
    fetch(16'h0014, 1'b0, -1, lat, rd, fb);
    check("refill_hit_lat", 32'(lat), 32'd1);
    // inv in the lookup cycle: this lookup still hits, the next one misses.
    fetch(16'h0014, 1'b0, 1, lat, rd, fb);
    check("invlk_lat", 32'(lat), 32'd1);
    check("invlk_rdata", rd, 32'h1005);
    fetch(16'h0014, 1'b0, -1, lat, rd, fb);
    check("invlk_after_lat", 32'(lat), 32'd6);
`ifdef ICACHE_PERF_EN
    check("perf_hits", hit_cnt, 32'd7);
    check("perf_miss", miss_cnt, 32'd8);
`endif

    // Reset after two acks of a fill.
    bus.imem_addr = 16'h0000;
    bus.imem_oe   = 1'b1;
    tick;
    bus.imem_oe = 1'b0;
    tick;
    tick;
    tick;
    check("mid_bkreq", 32'(bus.bk_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_bkreq", 32'(bus.bk_req), 32'd0);
    check("arst_ready", 32'(bus.imem_ready), 32'd1);
    ack_force = 1'b1;
    @(negedge clk) rst = 1'b1;
    tick;
    tick;
    check("late_ack_bkreq", 32'(bus.bk_req), 32'd0);
    check("late_ack_ready", 32'(bus.imem_ready), 32'd1);
    ack_force = 1'b0;
    tick;
`ifdef ICACHE_PERF_EN
    check("perf_rst_hits", hit_cnt, 32'd0);
    check("perf_rst_miss", miss_cnt, 32'd0);
`endif
    fetch(16'h0000, 1'b0, -1, lat, rd, fb);
    check("post_rst_lat", 32'(lat), 32'd6);
    check("post_rst_rdata", rd, 32'h1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
